alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 30 +++
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encodings and an opcode-legality helper.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: op_legal = 1'b1;
            default:                                            op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND, OR, ADD, SUB, signed SLT, NOR. Unknown opcodes yield zero.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;

    assign sa = a;
    assign sb = b;

    always_comb begin
        y = '0;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, (sa < sb)};
            ALU_NOR: y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU with a single registered result slot.
// Define ALU_ARB_RR_EN for round-robin priority; otherwise requester 0 always wins.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter logic [DATA_W-1:0] ILLEGAL_VAL = 32'h0000_0000
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              illegal
);

    logic              prio;
    logic              slot_free;
    logic              arb_en;
    logic [OP_W-1:0]   op_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [DATA_W-1:0] alu_y_p0;
    logic              legal_p0;
    logic [DATA_W-1:0] res_nxt_p0;

    logic              vld_p1;
    logic              id_p1;
    logic [DATA_W-1:0] result_p1;
    logic              zero_p1;
    logic              illegal_p1;

    assign slot_free = !vld_p1 || res_ready;
    assign arb_en    = !rst && slot_free;

    assign gnt0 = arb_en && req0 && (!req1 || !prio);
    assign gnt1 = arb_en && req1 && (!req0 ||  prio);

    // Stage p0: operand select and compute for the granted requester
    assign op_p0 = gnt1 ? op1 : op0;
    assign a_p0  = gnt1 ? a1  : a0;
    assign b_p0  = gnt1 ? b1  : b0;

    alu u_alu (
        .op (op_p0),
        .a  (a_p0),
        .b  (b_p0),
        .y  (alu_y_p0)
    );

    assign legal_p0   = op_legal(op_p0);
    assign res_nxt_p0 = legal_p0 ? alu_y_p0 : ILLEGAL_VAL;

    // Stage p1: result slot, loaded on grant and drained on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            id_p1      <= 1'b0;
            result_p1  <= '0;
            zero_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
            prio       <= 1'b0;
        end else if (gnt0 || gnt1) begin
            vld_p1     <= 1'b1;
            id_p1      <= gnt1;
            result_p1  <= res_nxt_p0;
            zero_p1    <= (res_nxt_p0 == '0);
            illegal_p1 <= !legal_p0;
`ifdef ALU_ARB_RR_EN
            prio       <= gnt0;
`else
            prio       <= 1'b0;
`endif
        end else if (res_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign res_valid = vld_p1;
    assign res_id    = id_p1;
    assign result    = result_p1;
    assign zero      = zero_p1;
    assign illegal   = illegal_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (honours ALU_ARB_RR_EN when defined).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1;
    logic        res_valid, res_ready, res_id;
    logic [31:0] result;
    logic        zero, illegal;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] held;
    logic        exp_id [4];

    always #5 clk = ~clk;

    alu_arbiter #(.ILLEGAL_VAL(32'hDEAD_BEEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request from requester n, granted immediately, result checked next cycle
    task automatic issue(input logic n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill);
        if (n) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else   begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        #1;
        check("gnt0", {31'b0, gnt0}, {31'b0, !n});
        check("gnt1", {31'b0, gnt1}, {31'b0, n});
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        check("valid", {31'b0, res_valid}, 32'd1);
        check("id", {31'b0, res_id}, {31'b0, n});
        check("result", result, exp_res);
        check("zero", {31'b0, zero}, {31'b0, exp_zero});
        check("illegal", {31'b0, illegal}, {31'b0, exp_ill});
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("rst_gnt0", {31'b0, gnt0}, 32'd0);
        check("rst_gnt1", {31'b0, gnt1}, 32'd0);
        step();
        check("rst_valid", {31'b0, res_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_id", {31'b0, res_id}, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0; res_ready = 1'b1;
        step();

        issue(1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        issue(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        issue(1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        issue(1'b0, 4'b0011, 32'd1, 32'd2, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(1'b0, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        issue(1'b0, 4'b1111, 32'd3, 32'd3, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(1'b1, 4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        issue(1'b0, 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        issue(1'b0, 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(1'b0, 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        issue(1'b1, 4'b0111, 32'h8000_0000, 32'd0, 32'd1, 1'b0, 1'b0);

        // Contention: both requesting for four cycles, slot always drained
`ifdef ALU_ARB_RR_EN
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        req0 = 1'b1; op0 = 4'b0010; a0 = 32'd10; b0 = 32'd1;
        req1 = 1'b1; op1 = 4'b0010; a1 = 32'd20; b1 = 32'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_gnt0", {31'b0, gnt0}, {31'b0, !exp_id[i]});
            check("cont_gnt1", {31'b0, gnt1}, {31'b0, exp_id[i]});
            step();
            check("cont_id", {31'b0, res_id}, {31'b0, exp_id[i]});
            check("cont_result", result, exp_id[i] ? 32'd22 : 32'd11);
        end
        held = exp_id[3] ? 32'd22 : 32'd11;

        // Backpressure holds the slot and blocks grants
        req0 = 1'b0; res_ready = 1'b0;
        req1 = 1'b1; op1 = 4'b0010; a1 = 32'd100; b1 = 32'd23;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("bp_gnt1", {31'b0, gnt1}, 32'd0);
            step();
            check("bp_valid", {31'b0, res_valid}, 32'd1);
            check("bp_result", result, held);
            check("bp_id", {31'b0, res_id}, {31'b0, exp_id[3]});
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_gnt1", {31'b0, gnt1}, 32'd1);
        step();
        req1 = 1'b0;
        check("b2b_valid", {31'b0, res_valid}, 32'd1);
        check("b2b_result", result, 32'd123);
        check("b2b_id", {31'b0, res_id}, 32'd1);
        step();
        check("drain_valid", {31'b0, res_valid}, 32'd0);
        step();
        check("idle_valid", {31'b0, res_valid}, 32'd0);

        // Reset while a result is held and not consumed
        issue(1'b0, 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        res_ready = 1'b0; rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        #1;
        check("mid_rst_gnt0", {31'b0, gnt0}, 32'd0);
        check("mid_rst_gnt1", {31'b0, gnt1}, 32'd0);
        step();
        check("mid_rst_valid", {31'b0, res_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_id", {31'b0, res_id}, 32'd0);
        rst = 1'b0; res_ready = 1'b1;
        op0 = 4'b0001; a0 = 32'd4; b0 = 32'd1;
        op1 = 4'b0001; a1 = 32'd8; b1 = 32'd1;
        #1;
        check("post_rst_gnt0", {31'b0, gnt0}, 32'd1);
        check("post_rst_gnt1", {31'b0, gnt1}, 32'd0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        check("post_rst_result", result, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
